// File: rtl/aec_pkg.sv
// Shared constants and helpers for the arithmetic expression calculator blocks.
package aec_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_EQ   = 8'd61;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {StIdle, StHi, StLo, StTerm} fmt_state_e;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] i_nib);
    if (i_nib < 4'd10) begin
      return ASCII_0 + {4'h0, i_nib};
    end
    return ASCII_A_LC + {4'h0, i_nib} - 8'd10;
  endfunction

endpackage

// File: rtl/aec_result_fifo.sv
// Synchronous result FIFO; full/empty derive from a registered occupancy count.
module aec_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 7,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/aec_result_fmt.sv
// Buffers 7-bit calculator results and streams each as two lowercase hex digits
// plus a terminator character over a valid/ready handshake.
module aec_result_fmt
  import aec_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  TERM_CHAR = ASCII_LF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_res_valid,
  input  logic [6:0] i_res_data,
  output logic       o_char_valid,
  output logic [7:0] o_char_out,
  input  logic       i_char_ready,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  fmt_state_e  r_state;
  logic [6:0]  r_hold;
  logic        r_char_valid;
  logic [7:0]  r_char_out;
  logic        r_overflow;

  logic [6:0]  w_head;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [AW:0] w_fifo_count;
  logic        w_xfer;
  logic        w_pop;
  logic        w_push;

  assign w_xfer = r_char_valid && i_char_ready;
  assign w_pop  = !w_fifo_empty && ((r_state == StIdle) || ((r_state == StTerm) && w_xfer));
  assign w_push = i_res_valid && (!w_fifo_full || w_pop);

  aec_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (7)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (i_res_data),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_hold       <= '0;
      r_char_valid <= 1'b0;
      r_char_out   <= 8'h00;
      r_overflow   <= 1'b0;
    end else begin
      if (i_res_valid && !w_push) r_overflow <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_hold       <= w_head;
            r_char_out   <= nibble_to_ascii({1'b0, w_head[6:4]});
            r_char_valid <= 1'b1;
            r_state      <= StHi;
          end
        end
        StHi: begin
          if (w_xfer) begin
            r_char_out <= nibble_to_ascii(r_hold[3:0]);
            r_state    <= StLo;
          end
        end
        StLo: begin
          if (w_xfer) begin
            r_char_out <= TERM_CHAR;
            r_state    <= StTerm;
          end
        end
        StTerm: begin
          if (w_xfer) begin
            // Chain straight into the next result so the stream has no bubble.
            if (w_pop) begin
              r_hold     <= w_head;
              r_char_out <= nibble_to_ascii({1'b0, w_head[6:4]});
              r_state    <= StHi;
            end else begin
              r_char_valid <= 1'b0;
              r_state      <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_char_valid = r_char_valid;
  assign o_char_out   = r_char_out;
  assign o_overflow   = r_overflow;
  assign o_busy       = (w_fifo_count != '0) || (r_state != StIdle);

endmodule

// File: tb/tb_aec_result_fmt.sv
// Scoreboard bench for aec_result_fmt: driver feeds a result-level model, monitor checks stream.
module tb_aec_result_fmt;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       res_valid = 1'b0;
  logic [6:0] res_data = '0;
  logic       char_ready = 1'b0;
  logic       char_valid;
  logic [7:0] char_out;
  logic       busy;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: accepted results awaiting the serialiser, characters still
  // owed for the result being sent, and the expected character stream.
  byte unsigned exp_q[$];
  logic [6:0]   m_fifo[$];
  int           m_left = 0;
  bit           m_ovf = 1'b0;
  bit           exp_valid = 1'b0;
  bit           exp_busy = 1'b0;
  bit           exp_ovf = 1'b0;

  always #5 clk = ~clk;

  aec_result_fmt #(
    .DEPTH     (DEPTH),
    .TERM_CHAR (8'h0A)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_res_valid  (res_valid),
    .i_res_data   (res_data),
    .o_char_valid (char_valid),
    .o_char_out   (char_out),
    .i_char_ready (char_ready),
    .o_busy       (busy),
    .o_overflow   (overflow)
  );

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the model to the following cycle.
  task automatic step(input bit r, input bit rv, input logic [6:0] d, input bit rdy);
    @(posedge clk);
    #1;
    rst        = r;
    res_valid  = rv;
    res_data   = d;
    char_ready = rdy;
    exp_valid  = (m_left != 0);
    exp_busy   = (m_left != 0) || (m_fifo.size() != 0);
    exp_ovf    = m_ovf;
    if (r) begin
      m_fifo.delete();
      exp_q.delete();
      m_left = 0;
      m_ovf  = 1'b0;
    end else begin
      bit pop;
      bit acc;
      pop = (m_fifo.size() != 0) && ((m_left == 0) || ((m_left == 1) && rdy));
      acc = rv && ((m_fifo.size() < DEPTH) || pop);
      if (pop) begin
        void'(m_fifo.pop_front());
        m_left = 3;
      end else if ((m_left != 0) && rdy) begin
        m_left--;
      end
      if (acc) begin
        string s;
        m_fifo.push_back(d);
        s = $sformatf("%02x", d);
        exp_q.push_back(s[0]);
        exp_q.push_back(s[1]);
        exp_q.push_back(8'h0A);
      end else if (rv) begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if ((m_left == 0) && (m_fifo.size() == 0)) break;
      step(1'b0, 1'b0, 7'd0, 1'b1);
    end
    step(1'b0, 1'b0, 7'd0, 1'b1);
    @(negedge clk);
    chk("drain_stream_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("char_valid", int'(char_valid), int'(exp_valid));
      chk("busy", int'(busy), int'(exp_busy));
      chk("overflow", int'(overflow), int'(exp_ovf));
      if (char_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL char_out: got 0x%0h, expected no character at %0t", char_out, $time);
        end else begin
          chk("char_out", int'(char_out), int'(exp_q[0]));
          if (char_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [6:0] vals [3];
    step(1'b1, 1'b0, 7'd0, 1'b0);
    step(1'b0, 1'b0, 7'd0, 1'b0);
    @(negedge clk);
    chk("reset_char_out", int'(char_out), 8'h00);

    // Single result 45 -> "2d\n".
    step(1'b0, 1'b1, 7'd45, 1'b1);
    drain();

    // Back-to-back 0, 127, 10.
    vals = '{7'd0, 7'd127, 7'd10};
    foreach (vals[i]) step(1'b0, 1'b1, vals[i], 1'b1);
    drain();

    // Stall in the middle of result 0x59.
    step(1'b0, 1'b1, 7'h59, 1'b1);
    step(1'b0, 1'b0, 7'd0, 1'b1);
    step(1'b0, 1'b0, 7'd0, 1'b0);
    step(1'b0, 1'b0, 7'd0, 1'b0);
    drain();

    // Six results with consumer stalled: one held, four queued, one dropped.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 7'(8 * i + 3), 1'b0);
    drain();
    chk("overflow_sticky", int'(overflow), 1);

    // Full FIFO written in the same cycle as the TERM->HI pop.
    step(1'b1, 1'b0, 7'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 7'(i + 100), 1'b0);
    step(1'b0, 1'b0, 7'd0, 1'b1);
    step(1'b0, 1'b0, 7'd0, 1'b1);
    step(1'b0, 1'b1, 7'h7e, 1'b1);
    drain();
    chk("full_pop_no_overflow", int'(overflow), 0);

    // Reset while in LO with two results queued.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 7'(i + 20), 1'b0);
    step(1'b0, 1'b0, 7'd0, 1'b1);
    step(1'b1, 1'b0, 7'd0, 1'b1);
    step(1'b0, 1'b0, 7'd0, 1'b1);
    @(negedge clk);
    chk("post_rst_valid", int'(char_valid), 0);
    chk("post_rst_busy", int'(busy), 0);
    step(1'b0, 1'b1, 7'h3c, 1'b1);
    drain();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 40,
           7'($urandom_range(0, 127)), $urandom_range(0, 99) < 65);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
